// File: rtl/fetch_unit_if.sv
// Fetch unit signal bundle: control inputs, instruction-memory port and IF/ID outputs.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_unit_if;
  localparam int unsigned XLEN = 16;

  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rd_en;
  logic [XLEN-1:0] imem_data_in;
  logic            imem_data_valid;
  logic [XLEN-1:0] PC_out_to_IFID;
  logic [XLEN-1:0] imem_data_out_to_IFID;
  logic            fetch_stall;
  logic            halted;

  modport master (
    input  stall, branch_taken, branch_target, imem_data_in, imem_data_valid,
    output imem_addr, imem_rd_en, PC_out_to_IFID, imem_data_out_to_IFID,
           fetch_stall, halted
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_data_in, imem_data_valid,
    input  imem_addr, imem_rd_en, PC_out_to_IFID, imem_data_out_to_IFID,
           fetch_stall, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, memory-wait handling, branch redirect/flush.
// Define HALT_DETECT_EN to stop fetching after an opcode-4'hF word is delivered.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int unsigned XLEN = 16;
  localparam int unsigned SW   = 2;

  localparam logic [SW-1:0] FETCH    = 2'd0;
  localparam logic [SW-1:0] WAIT_MEM = 2'd1;
`ifdef HALT_DETECT_EN
  localparam logic [SW-1:0] HALT     = 2'd2;
`endif

  logic [XLEN-1:0] pc_q, pc_d;
  logic [SW-1:0]   state_q, state_d;
  logic [XLEN-1:0] pc_plus2;
  logic            in_halt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= FETCH;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_plus2 = pc_q + XLEN'(2);
`ifdef HALT_DETECT_EN
    in_halt  = (state_q == HALT);
`else
    in_halt  = 1'b0;
`endif

    pc_d                      = pc_q;
    state_d                   = state_q;
    bus.imem_addr             = pc_q;
    bus.imem_rd_en            = 1'b1;
    bus.PC_out_to_IFID        = pc_plus2;
    bus.imem_data_out_to_IFID = NOP_INSTR;
    bus.fetch_stall           = 1'b0;
    bus.halted                = 1'b0;

    // Outputs: a branch flushes the delivered word even when memory is valid.
    if (in_halt) begin
      bus.imem_rd_en = 1'b0;
      bus.halted     = 1'b1;
    end else begin
      bus.fetch_stall = !bus.imem_data_valid;
      if (bus.imem_data_valid && !bus.branch_taken)
        bus.imem_data_out_to_IFID = bus.imem_data_in;
    end

    // Next PC/state: branch > stall > (halt hold) > delivery > memory wait.
    if (bus.branch_taken) begin
      pc_d    = bus.branch_target;
      state_d = FETCH;
    end else if (!bus.stall && !in_halt) begin
      if (bus.imem_data_valid) begin
`ifdef HALT_DETECT_EN
        if (bus.imem_data_in[15:12] == 4'hF) begin
          state_d = HALT;
        end else begin
          pc_d    = pc_plus2;
          state_d = FETCH;
        end
`else
        pc_d    = pc_plus2;
        state_d = FETCH;
`endif
      end else begin
        state_d = WAIT_MEM;
      end
    end
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 16'h0000, instruction word driven to IF/ID when fetch produces no valid instruction.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port stall  input  1  hazard hold; PC SHALL NOT advance.
REQ-006 SHALL have port branch_taken  input  1  redirect request from ID.
REQ-007 SHALL have port branch_target  input  16  redirect address.
REQ-008 SHALL have port imem_addr  output  16  instruction memory address, equal to the current PC.
REQ-009 SHALL have port imem_rd_en  output  1  instruction memory read request.
REQ-010 SHALL have port imem_data_in  input  16  instruction word from memory.
REQ-011 SHALL have port imem_data_valid  input  1  imem_data_in is valid for imem_addr this cycle.
REQ-012 SHALL have port PC_out_to_IFID  output  16  PC+2 of the delivered instruction.
REQ-013 SHALL have port imem_data_out_to_IFID  output  16  delivered instruction or NOP_INSTR.
REQ-014 SHALL have port fetch_stall  output  1  high when no valid instruction is delivered because of a memory wait.
REQ-015 SHALL have port halted  output  1  high in HALT state.

Function
REQ-016 SHALL hold a 16-bit PC register and a 3-state FSM: FETCH, WAIT_MEM, HALT.
REQ-017 SHALL drive imem_addr = PC combinationally in all states; imem_rd_en = 1 in FETCH and WAIT_MEM, 0 in HALT.
REQ-018 SHALL compute PC+2 modulo 2^16 (0xFFFE+2 = 0x0000), with no carry out.
REQ-019 In FETCH with imem_data_valid=1: SHALL pass imem_data_in to imem_data_out_to_IFID and PC+2 to PC_out_to_IFID in the same cycle (zero latency), with fetch_stall=0.
REQ-020 In FETCH or WAIT_MEM with imem_data_valid=0: SHALL drive NOP_INSTR, assert fetch_stall, hold PC, and move to or stay in WAIT_MEM.
REQ-021 In WAIT_MEM with imem_data_valid=1: SHALL behave as REQ-019 and return to FETCH.
REQ-022 PC update priority, highest first: rst -> RESET_PC; branch_taken -> branch_target; stall -> hold; valid delivery -> PC+2; else hold.
REQ-023 branch_taken in any state SHALL drive NOP_INSTR that cycle (flush), load branch_target, and go to FETCH; it SHALL override stall and a simultaneous valid or HLT word.
REQ-024 stall=1 without branch_taken SHALL hold PC and state; the outputs SHALL still follow REQ-019/020.
REQ-025 A delivered word with [15:12]==4'hF and no branch_taken or stall SHALL pass to IF/ID, hold PC, and move to HALT (see REQ-030).
REQ-026 In HALT, the block SHALL drive NOP_INSTR, fetch_stall=0, and halted=1; it SHALL leave HALT only on rst or branch_taken.
REQ-027 PC_out_to_IFID SHALL equal PC+2 whenever NOP_INSTR is driven.

Reset
REQ-028 A synchronous rst SHALL set PC=RESET_PC and state=FETCH on the next edge, including from WAIT_MEM or HALT mid-operation, and SHALL take priority over all inputs.
REQ-029 After reset, the outputs SHALL be: halted=0, imem_addr=RESET_PC, imem_rd_en=1, and fetch_stall set by imem_data_valid.

Configuration
REQ-030 Macro HALT_DETECT_EN: when defined, REQ-025/026 apply. When undefined, there SHALL be no HALT state, halted SHALL be tied 0, and opcode 4'hF SHALL be fetched as an ordinary instruction.

Verification
REQ-031 Reset then valid held high for 4 cycles: imem_addr sequence 0x0000, 0x0002, 0x0004, 0x0006; PC_out_to_IFID one step ahead.
REQ-032 imem_data_valid low for 3 cycles at PC=0x0010: fetch_stall=1 and NOP_INSTR for 3 cycles, PC stays 0x0010, then the instruction is delivered and PC becomes 0x0012.
REQ-033 branch_taken=1, target 0x0100, with stall=1 and valid=1 in the same cycle: NOP driven that cycle and PC=0x0100 next cycle.
REQ-034 Fetch 0xF000 at 0x0020 with HALT_DETECT_EN defined: halted=1, PC frozen at 0x0020, imem_rd_en=0; then rst gives PC=0x0000 and halted=0.
REQ-035 PC=0xFFFE with a valid fetch: PC_out_to_IFID=0x0000, and the next imem_addr is 0x0000.
